// File: rtl/fifo_pkg.sv
// Shared types, default sizing and helpers for the parametrised FIFO controller.
// The FIFO_FWFT_EN macro (read mode) is consumed by fifo_ctrl_param, not here.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_DEPTH      = 8;

  // Encoding matches {wr_acc, rd_acc} so the accept bits cast straight in.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic fifo_status_t decode_status(input int occupancy,
                                                 input int depth,
                                                 input int afull_lvl,
                                                 input int aempty_lvl);
    fifo_status_t s;
    s.full         = (occupancy == depth);
    s.empty        = (occupancy == 0);
    s.almost_full  = (occupancy >= afull_lvl);
    s.almost_empty = (occupancy <= aempty_lvl);
    return s;
  endfunction

endpackage

// File: rtl/fifo_ctrl_param_memoria_dp.sv
// Storage array for fifo_ctrl_param: DEPTH x DATA_WIDTH registers,
// one synchronous write port and one asynchronous read port.
module memoria_dp #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the controller's
  // pointers and count, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO controller with occupancy count, watermarks and
// overflow/underflow pulses. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_ctrl_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AFULL_LVL  = 6,
  parameter int AEMPTY_LVL = 2,
  parameter int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_W-1:0]     wr_ptr,
  output logic [ADDR_W-1:0]     rd_ptr
);

  localparam logic [ADDR_W-1:0] PTR_INC = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_INC = {{ADDR_W{1'b0}}, 1'b1};

  logic                  wr_acc;
  logic                  rd_acc;
  fifo_op_e              op;
  fifo_status_t          status;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come only from the registered count, never from the request inputs.
  assign status       = decode_status(int'(count), DEPTH, AFULL_LVL, AEMPTY_LVL);
  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  // A write into a full FIFO is still taken when a pop frees the slot this cycle.
  assign rd_acc = rd_enable & ~empty;
  assign wr_acc = wr_enable & (~full | rd_acc);
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  memoria_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_INC;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_INC;
      end
      unique case (op)
        OP_WR:   count <= count + CNT_INC;
        OP_RD:   count <= count - CNT_INC;
        default: count <= count;
      endcase
      overflow  <= wr_enable & ~wr_acc;
      underflow <= rd_enable & ~rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown straight from the storage register; rd_enable pops it.
  assign data_out   = empty ? '0 : mem_rdata;
  assign data_valid = ~empty;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      if (rd_acc) begin
        data_out <= mem_rdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Directed, table-driven bench for fifo_ctrl_param (DATA_WIDTH=10, DEPTH=8).
// Works for both the standard read and the FIFO_FWFT_EN build.
module tb_fifo_ctrl_param;

  logic       clk;
  logic       reset;
  logic       wr_enable;
  logic [9:0] data_in;
  logic       rd_enable;
  logic [9:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_ctrl_param #(
    .DATA_WIDTH (10),
    .DEPTH      (8),
    .AFULL_LVL  (6),
    .AEMPTY_LVL (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_enable    (wr_enable),
    .data_in      (data_in),
    .rd_enable    (rd_enable),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [9:0] din;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ov;
    logic       un;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic rd, input logic [9:0] din,
                              input logic [3:0] cnt, input logic f, input logic e,
                              input logic af, input logic ae, input logic ov,
                              input logic un);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
    v.full = f; v.empty = e; v.af = af; v.ae = ae; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] din);
    wr_enable = 1'b1;
    data_in   = din;
    tick();
    wr_enable = 1'b0;
  endtask

  // Pop one word (optionally writing at the same time) and check the word read.
  task automatic pop(input logic [9:0] exp, input logic wr, input logic [9:0] din,
                     input string name);
`ifdef FIFO_FWFT_EN
    check({name, " data_out"}, 32'(data_out), 32'(exp));
    check({name, " data_valid"}, 32'(data_valid), 32'd1);
`endif
    rd_enable = 1'b1;
    wr_enable = wr;
    data_in   = din;
    tick();
    rd_enable = 1'b0;
    wr_enable = 1'b0;
`ifndef FIFO_FWFT_EN
    check({name, " data_out"}, 32'(data_out), 32'(exp));
    check({name, " data_valid"}, 32'(data_valid), 32'd1);
`endif
  endtask

  vec_t       tbl[10];
  logic [9:0] held;
  logic [2:0] exp_ptr;

  initial begin
    reset     = 1'b0;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    data_in   = '0;

    tbl[0] = mk(1'b1, 1'b0, 10'h001, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[1] = mk(1'b1, 1'b0, 10'h002, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[2] = mk(1'b1, 1'b0, 10'h003, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3] = mk(1'b1, 1'b0, 10'h004, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4] = mk(1'b1, 1'b0, 10'h005, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5] = mk(1'b1, 1'b0, 10'h006, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[6] = mk(1'b1, 1'b0, 10'h007, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[7] = mk(1'b1, 1'b0, 10'h008, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[8] = mk(1'b1, 1'b0, 10'h3FF, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[9] = mk(1'b0, 1'b0, 10'h000, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst count", 32'(count), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst almost_empty", 32'(almost_empty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst almost_full", 32'(almost_full), 32'd0);
    check("rst data_valid", 32'(data_valid), 32'd0);
    check("rst data_out", 32'(data_out), 32'd0);
    check("rst ovf/unf", 32'({overflow, underflow}), 32'd0);
    check("rst ptrs", 32'({wr_ptr, rd_ptr}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: reset mid-traffic after five writes
    for (int i = 0; i < 5; i++) push(10'h0A0 + 10'(i));
    check("t1 count before reset", 32'(count), 32'd5);
    wr_enable = 1'b1;
    data_in   = 10'h0AF;
    reset     = 1'b0;
    #2;
    check("t1 count", 32'(count), 32'd0);
    check("t1 empty", 32'(empty), 32'd1);
    check("t1 almost_empty", 32'(almost_empty), 32'd1);
    check("t1 data_valid", 32'(data_valid), 32'd0);
    check("t1 wr_ptr", 32'(wr_ptr), 32'd0);
    wr_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // 2: fill, overflow, drain (table-driven fill)
    for (int i = 0; i < 10; i++) begin
      wr_enable = tbl[i].wr;
      rd_enable = tbl[i].rd;
      data_in   = tbl[i].din;
      tick();
      wr_enable = 1'b0;
      rd_enable = 1'b0;
      check($sformatf("t2[%0d] count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("t2[%0d] full", i), 32'(full), 32'(tbl[i].full));
      check($sformatf("t2[%0d] empty", i), 32'(empty), 32'(tbl[i].empty));
      check($sformatf("t2[%0d] almost_full", i), 32'(almost_full), 32'(tbl[i].af));
      check($sformatf("t2[%0d] almost_empty", i), 32'(almost_empty), 32'(tbl[i].ae));
      check($sformatf("t2[%0d] overflow", i), 32'(overflow), 32'(tbl[i].ov));
      check($sformatf("t2[%0d] underflow", i), 32'(underflow), 32'(tbl[i].un));
    end
    for (int i = 1; i <= 8; i++) pop(10'(i), 1'b0, 10'h000, $sformatf("t2 read%0d", i));
    check("t2 drained count", 32'(count), 32'd0);
    check("t2 drained empty", 32'(empty), 32'd1);
    tick();
    check("t2 idle data_valid", 32'(data_valid), 32'd0);

    // 3: read from empty
`ifdef FIFO_FWFT_EN
    held = 10'h000;
`else
    held = 10'h008;
`endif
    rd_enable = 1'b1;
    tick();
    rd_enable = 1'b0;
    check("t3 underflow", 32'(underflow), 32'd1);
    check("t3 data_out", 32'(data_out), 32'(held));
    check("t3 data_valid", 32'(data_valid), 32'd0);
    check("t3 rd_ptr", 32'(rd_ptr), 32'd0);
    check("t3 count", 32'(count), 32'd0);
    tick();
    check("t3 underflow pulse end", 32'(underflow), 32'd0);

    // 4: full with simultaneous write and read
    for (int i = 1; i <= 8; i++) push(10'(i));
    check("t4 full", 32'(full), 32'd1);
    pop(10'h001, 1'b1, 10'h0AA, "t4 both");
    check("t4 both count", 32'(count), 32'd8);
    check("t4 both overflow", 32'(overflow), 32'd0);
    check("t4 both full", 32'(full), 32'd1);
    for (int i = 2; i <= 8; i++) pop(10'(i), 1'b0, 10'h000, $sformatf("t4 read%0d", i));
    pop(10'h0AA, 1'b0, 10'h000, "t4 read new");
    check("t4 empty", 32'(empty), 32'd1);

    // 5: pointer wrap, three rounds of six writes then six reads
    exp_ptr = 3'd1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 6; k++) push(10'h100 + 10'(r * 16 + k));
      exp_ptr = exp_ptr + 3'd6;
      check($sformatf("t5 r%0d wr_ptr", r), 32'(wr_ptr), 32'(exp_ptr));
      for (int k = 0; k < 6; k++)
        pop(10'h100 + 10'(r * 16 + k), 1'b0, 10'h000, $sformatf("t5 r%0d k%0d", r, k));
      check($sformatf("t5 r%0d rd_ptr", r), 32'(rd_ptr), 32'(exp_ptr));
    end

    // 6: single write into empty; FWFT shows it without a read request
    push(10'h155);
    tick();
`ifdef FIFO_FWFT_EN
    check("t6 show data_out", 32'(data_out), 32'h155);
    check("t6 show data_valid", 32'(data_valid), 32'd1);
`else
    check("t6 no read data_valid", 32'(data_valid), 32'd0);
`endif
    pop(10'h155, 1'b0, 10'h000, "t6 pop");
    check("t6 empty", 32'(empty), 32'd1);
    tick();
    check("t6 after data_valid", 32'(data_valid), 32'd0);

    // Empty with both requests: write taken, read rejected
    rd_enable = 1'b1;
    wr_enable = 1'b1;
    data_in   = 10'h2AA;
    tick();
    rd_enable = 1'b0;
    wr_enable = 1'b0;
    check("t7 underflow", 32'(underflow), 32'd1);
    check("t7 count", 32'(count), 32'd1);
`ifdef FIFO_FWFT_EN
    check("t7 data_valid", 32'(data_valid), 32'd1);
`else
    check("t7 data_valid", 32'(data_valid), 32'd0);
`endif
    pop(10'h2AA, 1'b0, 10'h000, "t7 pop");
    check("t7 empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
